inst_prefetch_queue: RTL

- Fetch-side front end for the 5-stage RV32I core; sits between the instruction memory and the IF/ID pipeline register.
- Generates sequential fetch addresses and buffers returned instructions with their PCs in a small FIFO.
- Delivers instructions to decode over a valid/ready handshake.
- Flushes and restarts on a branch/jump redirect from EX, decoupling decode stalls from memory fetch.

---
 rtl/inst_prefetch_queue_if.sv | 30 +++
 rtl/inst_prefetch_queue.sv | 119 +++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue_if.sv
// Fetch front-end bundle: redirect from EX, instruction memory request/response,
// and the decode-side valid/ready delivery of {pc, inst}.
interface inst_prefetch_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4
);
    logic                    redirect_valid;
    logic [ADDR_WIDTH-1:0]   redirect_addr;
    logic                    imem_req_valid;
    logic [ADDR_WIDTH-1:0]   imem_req_addr;
    logic [INST_WIDTH-1:0]   imem_rsp_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [ADDR_WIDTH-1:0]   out_pc;
    logic [INST_WIDTH-1:0]   out_inst;
    logic [$clog2(DEPTH):0]  count;

    // Environment side: the core (redirect, decode ready) and instruction memory.
    modport master (
        output redirect_valid, redirect_addr, imem_rsp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, count
    );

    // Prefetch queue side.
    modport slave (
        input  redirect_valid, redirect_addr, imem_rsp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches to a 1-cycle-latency
// instruction memory, buffers {pc, inst} pairs in a small FIFO and hands them
// to decode. A redirect from EX flushes the queue and restarts fetch at the
// target in the same cycle.
module inst_prefetch_queue #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  reset,
    inst_prefetch_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(32'h00000013);

    logic [ADDR_WIDTH-1:0] fetch_pc_q,    fetch_pc_d;
    logic [PW-1:0]         rd_ptr_q,      rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q,      wr_ptr_d;
    logic [CW-1:0]         count_q,       count_d;
    logic                  inflight_q,    inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];

    logic                  push;
    logic                  pop;
    logic                  head_valid;
    logic [CW:0]           credit_used;

    assign head_valid  = (count_q != '0);
    // An outstanding request has already reserved a slot; a same-cycle pop
    // deliberately does not release one, which keeps the full check simple.
    assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};

    // Next-state: reset, then redirect, then normal push/pop/issue.
    always_comb begin
        fetch_pc_d         = fetch_pc_q;
        rd_ptr_d           = rd_ptr_q;
        wr_ptr_d           = wr_ptr_q;
        count_d            = count_q;
        inflight_d         = inflight_q;
        inflight_pc_d      = inflight_pc_q;
        push               = 1'b0;
        pop                = 1'b0;
        bus.imem_req_valid = 1'b0;
        bus.imem_req_addr  = fetch_pc_q;

        if (reset) begin
            fetch_pc_d = START_ADDR;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            inflight_d = 1'b0;
        end else if (bus.redirect_valid) begin
            // Flush everything, drop the returning stale word, and fetch the
            // target right away through the address bypass.
            bus.imem_req_valid = 1'b1;
            bus.imem_req_addr  = bus.redirect_addr;
            fetch_pc_d         = bus.redirect_addr + ADDR_WIDTH'(4);
            inflight_d         = 1'b1;
            inflight_pc_d      = bus.redirect_addr;
            rd_ptr_d           = '0;
            wr_ptr_d           = '0;
            count_d            = '0;
        end else begin
            push = inflight_q;
            pop  = head_valid && bus.out_ready;
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (!push && pop) count_d = count_q - CW'(1);

            if (credit_used < (CW+1)'(DEPTH)) begin
                bus.imem_req_valid = 1'b1;
                fetch_pc_d         = fetch_pc_q + ADDR_WIDTH'(4);
                inflight_d         = 1'b1;
                inflight_pc_d      = fetch_pc_q;
            end else begin
                inflight_d = 1'b0;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        fetch_pc_q    <= fetch_pc_d;
        rd_ptr_q      <= rd_ptr_d;
        wr_ptr_q      <= wr_ptr_d;
        count_q       <= count_d;
        inflight_q    <= inflight_d;
        inflight_pc_q <= inflight_pc_d;
    end

    // FIFO storage: the returning word is tagged with the PC that requested it.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= inflight_pc_q;
            inst_mem[wr_ptr_q] <= bus.imem_rsp_data;
        end
    end

    // Decode-side view of the head entry; NOP and PC 0 whenever nothing is offered.
    always_comb begin
        bus.out_valid = !reset && head_valid;
        bus.out_pc    = '0;
        bus.out_inst  = NOP_INST;
        if (bus.out_valid) begin
            bus.out_pc   = pc_mem[rd_ptr_q];
            bus.out_inst = inst_mem[rd_ptr_q];
        end
    end

    assign bus.count = count_q;

endmodule
